// File: rtl/chirp_profile_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// radar_ctrl_pkg
// Shared constants for the chirp profile sequencer: FSM state encoding,
// reset field values, packed parameter width and field offsets, plus small
// helpers for packing a profile word and sanitising the repeat count.
// ---------------------------------------------------------------------------
package radar_ctrl_pkg;

   localparam int CHIRP_PARAM_W = 96;

   localparam int CNT_MAX_LSB = 0;
   localparam int TUNE_LSB    = 32;
   localparam int FOFF_LSB    = 64;

   localparam logic [31:0] DEF_FREQ_OFF  = 32'h0000_0600;
   localparam logic [31:0] DEF_TUNE_COEF = 32'h0000_0001;
   localparam logic [31:0] DEF_CNT_MAX   = 32'h0000_0fff;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_ARMED = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_NEXT  = 3'd4;

   function automatic logic [CHIRP_PARAM_W-1:0] pack_chirp(
      input logic [31:0] freq_offset,
      input logic [31:0] tuning_coef,
      input logic [31:0] counter_max
   );
      logic [CHIRP_PARAM_W-1:0] p;
      p = '0;
      p[FOFF_LSB    +: 32] = freq_offset;
      p[TUNE_LSB    +: 32] = tuning_coef;
      p[CNT_MAX_LSB +: 32] = counter_max;
      return p;
   endfunction

   // A repeat count of zero would never advance; treat it as one pulse.
   function automatic logic [15:0] clamp_repeat(input logic [15:0] r);
      return (r == 16'd0) ? 16'd1 : r;
   endfunction

endpackage

// File: rtl/chirp_profile_sequencer_if.sv
// ---------------------------------------------------------------------------
// chirp_profile_sequencer_if
// Link between the profile sequencer and the chirp generator / pulse
// controller.
//   chirp_ready           generator -> sequencer  generator ready (level)
//   chirp_active          generator -> sequencer  high while chirping
//   chirp_done            generator -> sequencer  1-cycle pulse at chirp end
//   chirp_parameters_out  sequencer -> generator  {32'b0, foff, tune, cnt_max}
//   params_valid          sequencer -> generator  fields stable and armed
//   params_update         sequencer -> generator  1-cycle pulse on reload
// master: the sequencer side.  slave: the generator side.
// ---------------------------------------------------------------------------
interface chirp_profile_sequencer_if;

   logic                                  chirp_ready;
   logic                                  chirp_active;
   logic                                  chirp_done;
   logic [radar_ctrl_pkg::CHIRP_PARAM_W+31:0] chirp_parameters_out;
   logic                                  params_valid;
   logic                                  params_update;

   modport master (
      input  chirp_ready,
      input  chirp_active,
      input  chirp_done,
      output chirp_parameters_out,
      output params_valid,
      output params_update
   );

   modport slave (
      output chirp_ready,
      output chirp_active,
      output chirp_done,
      input  chirp_parameters_out,
      input  params_valid,
      input  params_update
   );

endinterface

// File: rtl/chirp_profile_sequencer_table.sv
// ---------------------------------------------------------------------------
// chirp_profile_table
// NUM_PROFILES x 96-bit profile store. Synchronous write, registered read.
// The read register samples the array before a same-edge write lands, so a
// simultaneous write and read of one entry returns the old contents.
//   aclk, aresetn   clock, async active-low reset (entries -> RST_ENTRY)
//   wr_en/addr/data table write port
//   rd_addr         entry to read; rd_data follows one clock later
// ---------------------------------------------------------------------------
module chirp_profile_table #(
   parameter int NUM_PROFILES = 8,
   parameter int IDX_W        = 3,
   parameter logic [radar_ctrl_pkg::CHIRP_PARAM_W-1:0] RST_ENTRY = '0
) (
   input  logic                                     aclk,
   input  logic                                     aresetn,
   input  logic                                     wr_en,
   input  logic [IDX_W-1:0]                         wr_addr,
   input  logic [radar_ctrl_pkg::CHIRP_PARAM_W-1:0] wr_data,
   input  logic [IDX_W-1:0]                         rd_addr,
   output logic [radar_ctrl_pkg::CHIRP_PARAM_W-1:0] rd_data
);
   import radar_ctrl_pkg::*;

   logic [CHIRP_PARAM_W-1:0] mem_q [NUM_PROFILES];
   logic [CHIRP_PARAM_W-1:0] mem_d [NUM_PROFILES];
   logic [CHIRP_PARAM_W-1:0] rd_data_q;
   logic [CHIRP_PARAM_W-1:0] rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
      rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_PROFILES; i++) begin
            mem_q[i] <= RST_ENTRY;
         end
         rd_data_q <= RST_ENTRY;
      end else begin
         mem_q     <= mem_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/chirp_profile_sequencer.sv
// ---------------------------------------------------------------------------
// chirp_profile_sequencer
// Steps the chirp generator through a table of profiles between pulses. Each
// profile is applied for cfg_repeat pulses; cfg_num_profiles profiles make a
// sweep. The output register only reloads in LOAD, never during a chirp.
//   aclk, aresetn         clock, async active-low reset
//   cfg_wr_*              profile table write port
//   cfg_num_profiles      profiles per sweep (0 -> 1, >NUM_PROFILES clamped)
//   cfg_repeat            pulses per profile (0 -> 1)
//   seq_enable            level, run the sequencer
//   seq_restart           pulse, restart sweep at entry 0
//   chirp_if              generator handshake and parameter output (master)
//   profile_index         entry whose data is in the output register
//   sweep_done            1-cycle pulse after the last pulse of a sweep
//   sweep_count           completed sweeps, wrapping
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | stopped, outputs hold last fields, params_valid low
// LOAD     | copy table[idx] into output register, params_update high
// ARMED    | fields valid, waiting for the chirp to start
// RUN      | chirp in progress, waiting for chirp_done
// NEXT     | advance rep/idx, decide reload / re-arm / stop
// ---------------------------------------------------------------------------
module chirp_profile_sequencer #(
   parameter int          NUM_PROFILES  = 8,
   parameter int          IDX_W         = 3,
   parameter logic [31:0] DEF_FREQ_OFF  = radar_ctrl_pkg::DEF_FREQ_OFF,
   parameter logic [31:0] DEF_TUNE_COEF = radar_ctrl_pkg::DEF_TUNE_COEF,
   parameter logic [31:0] DEF_CNT_MAX   = radar_ctrl_pkg::DEF_CNT_MAX
) (
   input  logic                                     aclk,
   input  logic                                     aresetn,
   input  logic                                     cfg_wr_en,
   input  logic [IDX_W-1:0]                         cfg_wr_addr,
   input  logic [radar_ctrl_pkg::CHIRP_PARAM_W-1:0] cfg_wr_data,
   input  logic [IDX_W:0]                           cfg_num_profiles,
   input  logic [15:0]                              cfg_repeat,
   input  logic                                     seq_enable,
   input  logic                                     seq_restart,
   chirp_profile_sequencer_if.master                chirp_if,
   output logic [IDX_W-1:0]                         profile_index,
   output logic                                     sweep_done,
   output logic [15:0]                              sweep_count
);
   import radar_ctrl_pkg::*;

   localparam logic [CHIRP_PARAM_W-1:0] RST_PARAMS =
      pack_chirp(DEF_FREQ_OFF, DEF_TUNE_COEF, DEF_CNT_MAX);
   localparam logic [IDX_W:0] MAX_NUM = NUM_PROFILES[IDX_W:0];
   localparam logic [IDX_W:0] ONE_NUM = {{IDX_W{1'b0}}, 1'b1};

   logic [2:0]               state_q,       state_d;
   logic [IDX_W-1:0]         idx_q,         idx_d;
   logic [15:0]              rep_q,         rep_d;
   logic [IDX_W:0]           num_q,         num_d;
   logic [15:0]              rep_max_q,     rep_max_d;
   logic [CHIRP_PARAM_W-1:0] params_q,      params_d;
   logic [IDX_W-1:0]         prof_idx_q,    prof_idx_d;
   logic [15:0]              sweep_count_q, sweep_count_d;
   logic                     sweep_done_c;

   logic [IDX_W:0]           num_clamped;
   logic [16:0]              rep_inc;
   logic [IDX_W:0]           idx_inc;
   logic [CHIRP_PARAM_W-1:0] tbl_rd_data;

   // Read address follows idx_d so the entry is already registered in the
   // table by the time the FSM sits in LOAD.
   chirp_profile_table #(
      .NUM_PROFILES (NUM_PROFILES),
      .IDX_W        (IDX_W),
      .RST_ENTRY    (RST_PARAMS)
   ) u_table (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (cfg_wr_en),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_addr (idx_d),
      .rd_data (tbl_rd_data)
   );

   always_comb begin
      num_clamped = cfg_num_profiles;
      if (cfg_num_profiles == '0) begin
         num_clamped = ONE_NUM;
      end else if (cfg_num_profiles > MAX_NUM) begin
         num_clamped = MAX_NUM;
      end
   end

   assign rep_inc = {1'b0, rep_q} + 17'd1;
   assign idx_inc = {1'b0, idx_q} + ONE_NUM;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rep_d         = rep_q;
      num_d         = num_q;
      rep_max_d     = rep_max_q;
      params_d      = params_q;
      prof_idx_d    = prof_idx_q;
      sweep_count_d = sweep_count_q;
      sweep_done_c  = 1'b0;

      // Restart wins over everything, including a same-cycle chirp_done.
      if (seq_restart) begin
         idx_d     = '0;
         rep_d     = '0;
         num_d     = num_clamped;
         rep_max_d = clamp_repeat(cfg_repeat);
         state_d   = seq_enable ? ST_LOAD : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (seq_enable && chirp_if.chirp_ready) begin
                  idx_d     = '0;
                  rep_d     = '0;
                  num_d     = num_clamped;
                  rep_max_d = clamp_repeat(cfg_repeat);
                  state_d   = ST_LOAD;
               end
            end
            ST_LOAD: begin
               params_d   = tbl_rd_data;
               prof_idx_d = idx_q;
               state_d    = ST_ARMED;
            end
            ST_ARMED: begin
               // A chirp short enough that active was never seen still
               // counts as a pulse.
               if (chirp_if.chirp_done) begin
                  state_d = ST_NEXT;
               end else if (chirp_if.chirp_active) begin
                  state_d = ST_RUN;
               end else if (!seq_enable) begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (chirp_if.chirp_done) begin
                  state_d = ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (rep_inc < {1'b0, rep_max_q}) begin
                  rep_d   = rep_inc[15:0];
                  state_d = ST_ARMED;
               end else begin
                  rep_d = '0;
                  if (idx_inc == num_q) begin
                     idx_d         = '0;
                     sweep_done_c  = 1'b1;
                     sweep_count_d = sweep_count_q + 16'd1;
                  end else begin
                     idx_d = idx_inc[IDX_W-1:0];
                  end
                  state_d = seq_enable ? ST_LOAD : ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         rep_q         <= '0;
         num_q         <= ONE_NUM;
         rep_max_q     <= 16'd1;
         params_q      <= RST_PARAMS;
         prof_idx_q    <= '0;
         sweep_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rep_q         <= rep_d;
         num_q         <= num_d;
         rep_max_q     <= rep_max_d;
         params_q      <= params_d;
         prof_idx_q    <= prof_idx_d;
         sweep_count_q <= sweep_count_d;
      end
   end

   assign chirp_if.chirp_parameters_out = {32'b0, params_q};
   assign chirp_if.params_valid         = (state_q == ST_ARMED) || (state_q == ST_RUN);
   assign chirp_if.params_update        = (state_q == ST_LOAD);
   assign profile_index                 = prof_idx_q;
   assign sweep_done                    = sweep_done_c;
   assign sweep_count                   = sweep_count_q;

endmodule
